// File: rtl/regfile_write_scheduler_if.sv
// Issue, writeback and register-file-port bundle for regfile_write_scheduler.
// Bypass signals exist only when WB_BYPASS_EN is defined.
interface regfile_write_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                 issueValid;
  logic [ADDR_W-1:0]    issueRs1;
  logic [ADDR_W-1:0]    issueRs2;
  logic                 issueUsesRs1;
  logic                 issueUsesRs2;
  logic                 issueWritesRd;
  logic [ADDR_W-1:0]    issueRd;
  logic                 issueStall;

  logic                 aluWbValid;
  logic [ADDR_W-1:0]    aluWbRd;
  logic [DATA_W-1:0]    aluWbData;
  logic                 aluWbReady;

  logic                 lsuWbValid;
  logic [ADDR_W-1:0]    lsuWbRd;
  logic [DATA_W-1:0]    lsuWbData;
  logic                 lsuWbReady;

  logic                 rfWrite;
  logic [ADDR_W-1:0]    rfRd;
  logic [DATA_W-1:0]    rfWriteData;
  logic [2**ADDR_W-1:0] busyMask;
  logic                 wbSpurious;
`ifdef WB_BYPASS_EN
  logic                 bypassHit1;
  logic                 bypassHit2;
  logic [DATA_W-1:0]    bypassData1;
  logic [DATA_W-1:0]    bypassData2;
`endif

  modport master (
    output issueValid, issueRs1, issueRs2,
    output issueUsesRs1, issueUsesRs2,
    output issueWritesRd, issueRd,
    input  issueStall,
    output aluWbValid, aluWbRd, aluWbData,
    input  aluWbReady,
    output lsuWbValid, lsuWbRd, lsuWbData,
    input  lsuWbReady,
`ifdef WB_BYPASS_EN
    input  bypassHit1, bypassHit2,
    input  bypassData1, bypassData2,
`endif
    input  rfWrite, rfRd, rfWriteData,
    input  busyMask, wbSpurious
  );

  modport slave (
    input  issueValid, issueRs1, issueRs2,
    input  issueUsesRs1, issueUsesRs2,
    input  issueWritesRd, issueRd,
    output issueStall,
    input  aluWbValid, aluWbRd, aluWbData,
    output aluWbReady,
    input  lsuWbValid, lsuWbRd, lsuWbData,
    output lsuWbReady,
`ifdef WB_BYPASS_EN
    output bypassHit1, bypassHit2,
    output bypassData1, bypassData2,
`endif
    output rfWrite, rfRd, rfWriteData,
    output busyMask, wbSpurious
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Scoreboard, hazard stall and ALU/LSU writeback arbiter for the regfile.
// Optional WB_BYPASS_EN forwards the in-flight write to the source operands.
module regfile_write_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                   clock,
  input logic                   reset,
  regfile_write_scheduler_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              ptr;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic              spur;

  logic              byp1;
  logic              byp2;
  logic              raw;
  logic              waw;
  logic              stall;
  logic              accept;
  logic              gnt_alu;
  logic              gnt_lsu;
  logic              gnt_any;
  logic [ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;

  function automatic logic hzd(
    input logic [NREG-1:0]   b,
    input logic [ADDR_W-1:0] r
  );
    hzd = b[r] && (r != '0);
  endfunction

`ifdef WB_BYPASS_EN
  assign byp1 = rf_we && (rf_rd == bus.issueRs1)
              && (bus.issueRs1 != '0);
  assign byp2 = rf_we && (rf_rd == bus.issueRs2)
              && (bus.issueRs2 != '0);
  assign bus.bypassHit1  = byp1;
  assign bus.bypassHit2  = byp2;
  assign bus.bypassData1 = rf_data;
  assign bus.bypassData2 = rf_data;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign raw = (bus.issueUsesRs1 && hzd(busy, bus.issueRs1) && !byp1)
            || (bus.issueUsesRs2 && hzd(busy, bus.issueRs2) && !byp2);
  assign waw = bus.issueWritesRd && hzd(busy, bus.issueRd);
  assign stall  = bus.issueValid && (raw || waw);
  assign accept = bus.issueValid && !stall;

  // ptr=0 favours ALU on contention, ptr=1 favours LSU
  assign gnt_alu = bus.aluWbValid && (!bus.lsuWbValid || !ptr);
  assign gnt_lsu = bus.lsuWbValid && (!bus.aluWbValid || ptr);
  assign gnt_any = gnt_alu || gnt_lsu;

  always_comb begin
    g_rd   = '0;
    g_data = '0;
    unique case (1'b1)
      gnt_alu: begin
        g_rd   = bus.aluWbRd;
        g_data = bus.aluWbData;
      end
      gnt_lsu: begin
        g_rd   = bus.lsuWbRd;
        g_data = bus.lsuWbData;
      end
      default: ;
    endcase
  end

  // set after clear so a same-edge set wins
  always_comb begin
    busy_nxt = busy;
    if (rf_we)
      busy_nxt[rf_rd] = 1'b0;
    if (accept && bus.issueWritesRd && bus.issueRd != '0)
      busy_nxt[bus.issueRd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy    <= '0;
      ptr     <= 1'b0;
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
      spur    <= 1'b0;
    end else begin
      busy  <= busy_nxt;
      if (bus.aluWbValid && bus.lsuWbValid)
        ptr <= ~ptr;
      rf_we <= gnt_any && (g_rd != '0);
      spur  <= gnt_any && (g_rd != '0) && !busy[g_rd];
      if (gnt_any) begin
        rf_rd   <= g_rd;
        rf_data <= g_data;
      end
    end
  end

  assign bus.issueStall  = stall;
  assign bus.aluWbReady  = gnt_alu;
  assign bus.lsuWbReady  = gnt_lsu;
  assign bus.rfWrite     = rf_we;
  assign bus.rfRd        = rf_rd;
  assign bus.rfWriteData = rf_data;
  assign bus.busyMask    = busy;
  assign bus.wbSpurious  = spur;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed self-checking bench for regfile_write_scheduler.
// Expectations follow WB_BYPASS_EN when it is defined.
module tb_regfile_write_scheduler;
  logic clock;
  logic reset;
  int   tests;
  int   fails;

  regfile_write_scheduler_if #(.DATA_W(32), .ADDR_W(5)) bus();

  regfile_write_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issueValid    = 1'b0;
    bus.issueRs1      = '0;
    bus.issueRs2      = '0;
    bus.issueUsesRs1  = 1'b0;
    bus.issueUsesRs2  = 1'b0;
    bus.issueWritesRd = 1'b0;
    bus.issueRd       = '0;
    bus.aluWbValid    = 1'b0;
    bus.aluWbRd       = '0;
    bus.aluWbData     = '0;
    bus.lsuWbValid    = 1'b0;
    bus.lsuWbRd       = '0;
    bus.lsuWbData     = '0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    bus.issueValid    = 1'b1;
    bus.issueWritesRd = 1'b1;
    bus.issueRd       = rd;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.aluWbValid = 1'b1;
    bus.aluWbRd    = rd;
    bus.aluWbData  = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    bus.lsuWbValid = 1'b1;
    bus.lsuWbRd    = rd;
    bus.lsuWbData  = d;
  endtask

  logic        byp;
  logic [4:0]  erd;
  logic [31:0] edat;
  int          ai;
  int          li;

  initial begin
    tests = 0;
    fails = 0;
`ifdef WB_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    reset = 1'b0;
    idle();
    #12;
    chk("rst_busy", bus.busyMask, 32'h0);
    chk("rst_we", {31'd0, bus.rfWrite}, 32'd0);
    chk("rst_rd", {27'd0, bus.rfRd}, 32'd0);
    chk("rst_data", bus.rfWriteData, 32'd0);
    chk("rst_spur", {31'd0, bus.wbSpurious}, 32'd0);
    reset = 1'b1;

    // contested grant flips pointer, then reset mid-write
    tick();
    alu(5'd5, 32'hAA);
    lsu(5'd0, 32'h11);
    #1;
    chk("mw_alu_rdy", {31'd0, bus.aluWbReady}, 32'd1);
    chk("mw_lsu_rdy", {31'd0, bus.lsuWbReady}, 32'd0);
    tick();
    idle();
    chk("mw_we", {31'd0, bus.rfWrite}, 32'd1);
    chk("mw_rd", {27'd0, bus.rfRd}, 32'd5);
    chk("mw_data", bus.rfWriteData, 32'hAA);
    chk("mw_spur", {31'd0, bus.wbSpurious}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("mw_rst_we", {31'd0, bus.rfWrite}, 32'd0);
    chk("mw_rst_busy", bus.busyMask, 32'h0);
    chk("mw_rst_spur", {31'd0, bus.wbSpurious}, 32'd0);
    #1;
    reset = 1'b1;
    alu(5'd1, 32'h1);
    lsu(5'd2, 32'h2);
    #1;
    chk("ptr_rst_alu", {31'd0, bus.aluWbReady}, 32'd1);
    chk("ptr_rst_lsu", {31'd0, bus.lsuWbReady}, 32'd0);
    idle();

    // RAW stall on x3
    tick();
    issue_wr(5'd3);
    #1;
    chk("raw_iss", {31'd0, bus.issueStall}, 32'd0);
    tick();
    idle();
    chk("raw_busy", bus.busyMask, 32'h8);
    alu(5'd3, 32'h33);
    bus.issueValid   = 1'b1;
    bus.issueUsesRs1 = 1'b1;
    bus.issueRs1     = 5'd3;
    #1;
    chk("raw_t_stall", {31'd0, bus.issueStall}, 32'd1);
    tick();
    bus.aluWbValid = 1'b0;
    chk("raw_t1_we", {31'd0, bus.rfWrite}, 32'd1);
    chk("raw_t1_rd", {27'd0, bus.rfRd}, 32'd3);
    chk("raw_t1_spur", {31'd0, bus.wbSpurious}, 32'd0);
    chk("raw_t1_stall", {31'd0, bus.issueStall}, {31'd0, !byp});
`ifdef WB_BYPASS_EN
    chk("raw_t1_hit1", {31'd0, bus.bypassHit1}, 32'd1);
    chk("raw_t1_bdat", bus.bypassData1, 32'h33);
    chk("raw_t1_hit2", {31'd0, bus.bypassHit2}, 32'd0);
`endif
    tick();
    chk("raw_t2_stall", {31'd0, bus.issueStall}, 32'd0);
    chk("raw_t2_busy", bus.busyMask, 32'h0);
    idle();

    // WAW and x0 never stalls
    issue_wr(5'd7);
    tick();
    chk("waw_busy", bus.busyMask, 32'h80);
    #1;
    chk("waw_stall", {31'd0, bus.issueStall}, 32'd1);
    bus.issueRd      = 5'd0;
    bus.issueUsesRs1 = 1'b1;
    bus.issueRs1     = 5'd0;
    #1;
    chk("x0_nostall", {31'd0, bus.issueStall}, 32'd0);
    bus.issueUsesRs2 = 1'b1;
    bus.issueRs2     = 5'd7;
    #1;
    chk("raw_rs2_stall", {31'd0, bus.issueStall}, 32'd1);
    bus.issueValid = 1'b0;
    #1;
    chk("novalid_stall", {31'd0, bus.issueStall}, 32'd0);
    idle();
    alu(5'd7, 32'h77);
    tick();
    idle();
    issue_wr(5'd7);
    #1;
    chk("waw_inflight", {31'd0, bus.issueStall}, 32'd1);
    idle();
    bus.issueValid   = 1'b1;
    bus.issueUsesRs1 = 1'b1;
    bus.issueRs1     = 5'd7;
    #1;
    chk("raw_inflight", {31'd0, bus.issueStall}, {31'd0, !byp});
    bus.issueValid = 1'b0;
    tick();
    chk("waw_clr", bus.busyMask, 32'h0);
    idle();

    // contention: ALU, LSU, ALU, LSU
    ai = 0;
    li = 0;
    for (int i = 0; i < 4; i++) begin
      alu(5'(10 + ai), 32'hA0 + 32'(ai));
      lsu(5'(20 + li), 32'hB0 + 32'(li));
      #1;
      chk("ct_alu_rdy", {31'd0, bus.aluWbReady},
          {31'd0, (i % 2) == 0});
      chk("ct_lsu_rdy", {31'd0, bus.lsuWbReady},
          {31'd0, (i % 2) == 1});
      tick();
      if ((i % 2) == 0) begin
        erd  = 5'(10 + i / 2);
        edat = 32'hA0 + 32'(i / 2);
        ai++;
      end else begin
        erd  = 5'(20 + i / 2);
        edat = 32'hB0 + 32'(i / 2);
        li++;
      end
      chk("ct_we", {31'd0, bus.rfWrite}, 32'd1);
      chk("ct_rd", {27'd0, bus.rfRd}, {27'd0, erd});
      chk("ct_data", bus.rfWriteData, edat);
    end
    idle();
    tick();
    chk("ct_end_we", {31'd0, bus.rfWrite}, 32'd0);

    // writeback to x0, then spurious to x9
    lsu(5'd0, 32'h55);
    #1;
    chk("x0_lsu_rdy", {31'd0, bus.lsuWbReady}, 32'd1);
    chk("x0_alu_rdy", {31'd0, bus.aluWbReady}, 32'd0);
    tick();
    idle();
    chk("x0_we", {31'd0, bus.rfWrite}, 32'd0);
    chk("x0_spur", {31'd0, bus.wbSpurious}, 32'd0);
    alu(5'd9, 32'h99);
    tick();
    idle();
    chk("sp_we", {31'd0, bus.rfWrite}, 32'd1);
    chk("sp_rd", {27'd0, bus.rfRd}, 32'd9);
    chk("sp_data", bus.rfWriteData, 32'h99);
    chk("sp_pulse", {31'd0, bus.wbSpurious}, 32'd1);
    tick();
    chk("sp_end", {31'd0, bus.wbSpurious}, 32'd0);
    chk("sp_busy", bus.busyMask, 32'h0);

    // clear x4 while issuing x6
    issue_wr(5'd4);
    tick();
    idle();
    alu(5'd4, 32'h44);
    tick();
    idle();
    issue_wr(5'd6);
    #1;
    chk("ic_stall", {31'd0, bus.issueStall}, 32'd0);
    tick();
    idle();
    chk("ic_busy", bus.busyMask, 32'h40);

    // same-index set and clear: set wins
    alu(5'd8, 32'h88);
    tick();
    idle();
    issue_wr(5'd8);
    tick();
    idle();
    chk("sw_busy", bus.busyMask, 32'h140);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
